sram_arbiter: RTL

- Sequences every access to the shared 64 KB sram64k.
- Arbitrates between three requesters: the SPI flash loader (image fill), the CPU bus (via ramenable decode) and the diagnostics module (halted-CPU memory access).
- Replaces the ad-hoc combinational muxing of address, data, cs and we with a registered, collision-free access scheduler, so each SRAM cycle has exactly one owner.

---
 rtl/sram_arbiter_if.sv | 58 +++++
 rtl/sram_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Request, CPU, SRAM-side and status signals of the shared-SRAM access scheduler.
// The slave modport is the arbiter; the master modport is its environment (requesters and sram64k).
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              load_done;
    logic              halt;

    logic              flash_req;
    logic              flash_we;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_wdata;
    logic              flash_ack;

    logic              diag_req;
    logic              diag_we;
    logic [ADDR_W-1:0] diag_addr;
    logic [DATA_W-1:0] diag_wdata;
    logic              diag_ack;

    logic              cpu_sel;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_cs;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    modport slave (
        input  load_done, halt,
        input  flash_req, flash_we, flash_addr, flash_wdata,
        output flash_ack,
        input  diag_req, diag_we, diag_addr, diag_wdata,
        output diag_ack,
        input  cpu_sel, cpu_we, cpu_addr, cpu_wdata,
        output rdata, ram_addr, ram_wdata, ram_cs, ram_we,
        input  ram_rdata,
        output busy
    );

    modport master (
        output load_done, halt,
        output flash_req, flash_we, flash_addr, flash_wdata,
        input  flash_ack,
        output diag_req, diag_we, diag_addr, diag_wdata,
        input  diag_ack,
        output cpu_sel, cpu_we, cpu_addr, cpu_wdata,
        input  rdata, ram_addr, ram_wdata, ram_cs, ram_we,
        output ram_rdata,
        input  busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Registered access scheduler for the shared 64 KB SRAM: one owner per IDLE->ISSUE->CAPTURE cycle,
// chosen among the flash loader, the CPU (reads and shadowed writes) and halted-CPU diagnostics.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    typedef enum logic [2:0] {OWN_NONE, OWN_FLASH, OWN_DIAG, OWN_CPU_RD, OWN_CPU_WR} owner_t;
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    state_t            state, state_n;
    owner_t            owner, owner_n;
    logic              acc_we, acc_we_n;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_n;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_n;
    logic              ram_cs_q, ram_cs_n;
    logic              ram_we_q, ram_we_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              flash_ack_q, flash_ack_n;
    logic              diag_ack_q, diag_ack_n;
    logic              busy_q, busy_n;
    logic              cpu_wr_pend, wr_pend_n;
    logic [ADDR_W-1:0] shadow_addr, shadow_addr_n;
    logic [DATA_W-1:0] shadow_wdata, shadow_wdata_n;
    logic              cpu_sel_q, cpu_we_q;
    logic              load_seen;

    logic              loaded;
    logic              cpu_fall;
    logic              wr_pending;
    logic              grant;
    owner_t            gnt_owner;
    acc_t              gnt_acc;

    // load_done is sticky so the flash loader can never regain the SRAM
    assign loaded     = bus.load_done || load_seen;
    assign cpu_fall   = loaded && cpu_sel_q && cpu_we_q && !bus.cpu_sel;
    // A write whose cpu_sel falls this very cycle already outranks diag
    assign wr_pending = cpu_wr_pend || cpu_fall;

    // Owner selection; a requester whose ack is high this cycle is masked
    always_comb begin : arbitrate
        grant     = 1'b0;
        gnt_owner = OWN_NONE;
        gnt_acc   = '0;
        if (!loaded) begin
            if (bus.flash_req && !flash_ack_q) begin
                grant     = 1'b1;
                gnt_owner = OWN_FLASH;
                gnt_acc   = {bus.flash_we, bus.flash_addr, bus.flash_wdata};
            end
        end else if (wr_pending) begin
            grant     = 1'b1;
            gnt_owner = OWN_CPU_WR;
            gnt_acc   = {1'b1, shadow_addr, shadow_wdata};
        end else if (!bus.halt) begin
            if (bus.cpu_sel && !bus.cpu_we) begin
                grant     = 1'b1;
                gnt_owner = OWN_CPU_RD;
                gnt_acc   = {1'b0, bus.cpu_addr, bus.cpu_wdata};
            end
        end else if (bus.diag_req && !diag_ack_q) begin
            grant     = 1'b1;
            gnt_owner = OWN_DIAG;
            gnt_acc   = {bus.diag_we, bus.diag_addr, bus.diag_wdata};
        end
    end

    always_comb begin : next_state
        state_n        = state;
        owner_n        = owner;
        acc_we_n       = acc_we;
        ram_addr_n     = ram_addr_q;
        ram_wdata_n    = ram_wdata_q;
        ram_cs_n       = 1'b0;
        ram_we_n       = 1'b0;
        rdata_n        = rdata_q;
        flash_ack_n    = 1'b0;
        diag_ack_n     = 1'b0;
        wr_pend_n      = cpu_wr_pend;
        shadow_addr_n  = shadow_addr;
        shadow_wdata_n = shadow_wdata;

        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_n     = ISSUE;
                    owner_n     = gnt_owner;
                    acc_we_n    = gnt_acc.we;
                    ram_addr_n  = gnt_acc.addr;
                    ram_wdata_n = gnt_acc.wdata;
                    ram_cs_n    = 1'b1;
                    ram_we_n    = gnt_acc.we;
                end
            end
            ISSUE: begin
                state_n = CAPTURE;
                if (owner == OWN_CPU_WR) wr_pend_n = 1'b0;
            end
            CAPTURE: begin
                if (!acc_we) rdata_n = bus.ram_rdata;
                flash_ack_n = (owner == OWN_FLASH);
                diag_ack_n  = (owner == OWN_DIAG);
                owner_n     = OWN_NONE;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Shadow follows the CPU bus during a write; a newer falling edge wins over a stale pend
        if (bus.cpu_sel && bus.cpu_we) begin
            shadow_addr_n  = bus.cpu_addr;
            shadow_wdata_n = bus.cpu_wdata;
        end
        if (cpu_fall) wr_pend_n = 1'b1;

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin : regs
        if (!reset) begin
            state        <= IDLE;
            owner        <= OWN_NONE;
            acc_we       <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            rdata_q      <= '0;
            flash_ack_q  <= 1'b0;
            diag_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            cpu_wr_pend  <= 1'b0;
            shadow_addr  <= '0;
            shadow_wdata <= '0;
            cpu_sel_q    <= 1'b0;
            cpu_we_q     <= 1'b0;
            load_seen    <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            acc_we       <= acc_we_n;
            ram_addr_q   <= ram_addr_n;
            ram_wdata_q  <= ram_wdata_n;
            ram_cs_q     <= ram_cs_n;
            ram_we_q     <= ram_we_n;
            rdata_q      <= rdata_n;
            flash_ack_q  <= flash_ack_n;
            diag_ack_q   <= diag_ack_n;
            busy_q       <= busy_n;
            cpu_wr_pend  <= wr_pend_n;
            shadow_addr  <= shadow_addr_n;
            shadow_wdata <= shadow_wdata_n;
            cpu_sel_q    <= bus.cpu_sel;
            cpu_we_q     <= bus.cpu_we;
            load_seen    <= loaded;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.rdata     = rdata_q;
    assign bus.flash_ack = flash_ack_q;
    assign bus.diag_ack  = diag_ack_q;
    assign bus.busy      = busy_q;
endmodule
